// File: rtl/servo_target_ramp.sv
// Servo target selection and ramp: synchronizes and debounces the position switches,
// decodes a one-hot choice into a high-time target and slews pulseWidth toward it once per frame.
module servo_target_ramp #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP            = 2000,
    parameter int BASE            = 26000,
    parameter int OFF30           = 12329,
    parameter int OFF60           = 26419,
    parameter int OFF90           = 41868,
    parameter int OFF120          = 57774,
    parameter int OFF150          = 75633,
    parameter int OFF180          = 92109
) (
    input  logic        relojNexys2,
    input  logic        rst_n,
    input  logic [5:0]  selectPos,
    input  logic        frameTick,
    output logic [16:0] pulseWidth,
    output logic [5:0]  ledAngulo,
    output logic        busy
);

    localparam logic [19:0] DEB_MAX  = 20'(DEBOUNCE_CYCLES);
    localparam logic [19:0] DEB_LOAD = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [16:0] STEP_V   = 17'(STEP);
    localparam logic [16:0] BASE_V   = 17'(BASE);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    logic [5:0]  sync1_q, sync1_d;
    logic [5:0]  sync2_q, sync2_d;
    logic [19:0] cnt_q, cnt_d;
    logic [5:0]  stable_q, stable_d;
    logic [16:0] target_q, target_d;
    logic [5:0]  led_q, led_d;
    logic [16:0] pw_q, pw_d;
    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic [16:0] diff_s;
    logic        up_s;

    function automatic logic is_onehot(input logic [5:0] sel);
        return (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [16:0] pos_target(input logic [5:0] sel);
        case (sel)
            6'b000001: return 17'(BASE + OFF30);
            6'b000010: return 17'(BASE + OFF60);
            6'b000100: return 17'(BASE + OFF90);
            6'b001000: return 17'(BASE + OFF120);
            6'b010000: return 17'(BASE + OFF150);
            6'b100000: return 17'(BASE + OFF180);
            default:   return BASE_V;
        endcase
    endfunction

    // Next-state logic for synchronizer, debounce, decode and ramp FSM.
    always_comb begin
        sync1_d  = selectPos;
        sync2_d  = sync1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        target_d = target_q;
        led_d    = led_q;
        pw_d     = pw_q;
        state_d  = state_q;
        diff_s   = 17'd0;
        up_s     = 1'b0;

        // A difference between the two sync stages means the synchronized value is changing.
        if (sync1_q != sync2_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q == DEB_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        if (cnt_q == DEB_LOAD) begin
            stable_d = sync2_q;
        end else begin
            stable_d = stable_q;
        end

        if (is_onehot(stable_q)) begin
            target_d = pos_target(stable_q);
            led_d    = stable_q;
        end else if (stable_q == 6'd0) begin
            target_d = target_q;
            led_d    = led_q;
        end else begin
            target_d = BASE_V;
            led_d    = 6'd0;
        end

        // Direction from the comparison so the subtraction never underflows.
        if (target_q >= pw_q) begin
            up_s   = 1'b1;
            diff_s = target_q - pw_q;
        end else begin
            up_s   = 1'b0;
            diff_s = pw_q - target_q;
        end

        case (state_q)
            IDLE: begin
                if (target_q != pw_q) begin
                    state_d = RAMP;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                if (frameTick) begin
                    if (diff_s <= STEP_V) begin
                        pw_d    = target_q;
                        state_d = IDLE;
                    end else if (up_s) begin
                        pw_d = pw_q + STEP_V;
                    end else begin
                        pw_d = pw_q - STEP_V;
                    end
                end else begin
                    pw_d = pw_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RAMP);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge relojNexys2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 6'd0;
            sync2_q  <= 6'd0;
            cnt_q    <= 20'd0;
            stable_q <= 6'd0;
            target_q <= BASE_V;
            led_q    <= 6'd0;
            pw_q     <= BASE_V;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            target_q <= target_d;
            led_q    <= led_d;
            pw_q     <= pw_d;
            state_q  <= state_d;
            busy_q   <= busy_d;
        end
    end

    assign pulseWidth = pw_q;
    assign ledAngulo  = led_q;
    assign busy       = busy_q;

endmodule
